// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter and its picker.
package wb_arb_pkg;

  localparam int MAX_M = 8;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_OWN
  } arb_state_e;

  // Index width for a vector of 'value' entries; never narrower than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req at or after ptr, wrapping.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Scan from the far end back towards ptr so the closest requester is written last.
  always_comb begin
    logic [IW-1:0] k;
    gnt = '0;
    idx = '0;
    k   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port between NUM_M masters.
// Define WB_ARB_TIMEOUT_EN to force an ERR after TIMEOUT_CYC stalled strobe cycles.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_M       = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_M-1:0]        m_cyc_i,
  input  logic [NUM_M-1:0]        m_stb_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M*AW-1:0]     m_addr_i,
  input  logic [NUM_M*DW-1:0]     m_data_i,
  input  logic [NUM_M*DW/8-1:0]   m_sel_i,
  output logic [DW-1:0]           m_data_o,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic [NUM_M-1:0]        m_err_o,
  output logic [NUM_M-1:0]        m_rty_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [AW-1:0]           s_addr_o,
  output logic [DW-1:0]           s_data_o,
  output logic [DW/8-1:0]         s_sel_o,
  input  logic [DW-1:0]           s_data_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  output logic [NUM_M-1:0]        gnt_o
);

  localparam int IW = clog2(NUM_M);
  localparam int SW = DW / 8;

  if (NUM_M < 2 || NUM_M > MAX_M || TIMEOUT_CYC < 1) begin : g_param_check
    $error("wb_rr_arbiter: unsupported parameter set");
  end

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    pick_idx;
  logic [NUM_M-1:0] pick_gnt;
  logic             owner_cyc;
  logic             s_stb_raw;
  logic             timeout_hit;

  logic [AW-1:0]    addr_arr [NUM_M];
  logic [DW-1:0]    data_arr [NUM_M];
  logic [SW-1:0]    sel_arr  [NUM_M];

  for (genvar k = 0; k < NUM_M; k++) begin : g_unpack
    assign addr_arr[k] = m_addr_i[k*AW +: AW];
    assign data_arr[k] = m_data_i[k*DW +: DW];
    assign sel_arr[k]  = m_sel_i[k*SW +: SW];
  end

  wb_rr_pick #(
    .N  (NUM_M),
    .IW (IW)
  ) u_pick (
    .req (m_cyc_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign owner_cyc = m_cyc_i[owner];
  assign m_data_o  = s_data_i;

  // Grant is captured on the request edge and held until the owner drops CYC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      ptr   <= '0;
      owner <= '0;
      gnt_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && |m_cyc_i) begin
        gnt_o <= pick_gnt;
        owner <= pick_idx;
      end else if (state == ST_OWN && !owner_cyc) begin
        gnt_o <= '0;
        ptr   <= (owner == IW'(NUM_M - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|m_cyc_i) state_nxt = ST_OWN;
      ST_OWN:  if (!owner_cyc) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_raw = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_data_o  = '0;
    s_sel_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_rty_o   = '0;
    if (state == ST_OWN) begin
      s_cyc_o        = owner_cyc;
      s_stb_raw      = owner_cyc & m_stb_i[owner];
      s_we_o         = m_we_i[owner];
      s_addr_o       = addr_arr[owner];
      s_data_o       = data_arr[owner];
      s_sel_o        = sel_arr[owner];
      m_ack_o[owner] = s_ack_i;
      m_err_o[owner] = s_err_i | timeout_hit;
      m_rty_o[owner] = s_rty_i;
    end
  end

  // The strobe is withdrawn from the slave during the forced-ERR cycle.
  assign s_stb_o = s_stb_raw & ~timeout_hit;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] to_cnt;
  logic          stalled;

  assign stalled     = s_stb_raw & ~(s_ack_i | s_err_i | s_rty_i);
  assign timeout_hit = stalled && (to_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt <= '0;
    end else if (!stalled || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomized and directed bench for wb_rr_arbiter against an owner/pointer reference model.
// Honours WB_ARB_TIMEOUT_EN (then runs with an 8-cycle timeout).
module tb_wb_rr_arbiter;

  localparam int NUM_M = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN  = 1'b1;
  localparam int TO_CYC = 8;
`else
  localparam bit TO_EN  = 1'b0;
  localparam int TO_CYC = 255;
`endif
  localparam int STALL_LEN = 1000;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [NUM_M-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [NUM_M*AW-1:0]   m_addr_i;
  logic [NUM_M*DW-1:0]   m_data_i;
  logic [NUM_M*SW-1:0]   m_sel_i;
  logic [DW-1:0]         m_data_o;
  logic [NUM_M-1:0]      m_ack_o, m_err_o, m_rty_o;
  logic                  s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]         s_addr_o;
  logic [DW-1:0]         s_data_o;
  logic [SW-1:0]         s_sel_o;
  logic [DW-1:0]         s_data_i;
  logic                  s_ack_i, s_err_i, s_rty_i;
  logic [NUM_M-1:0]      gnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus (-1 = idle), where the scan starts, stall run length.
  int mdl_owner = -1;
  int mdl_ptr   = 0;
  int mdl_stall = 0;

  wb_rr_arbiter #(
    .NUM_M       (NUM_M),
    .AW          (AW),
    .DW          (DW),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_we_i   (m_we_i),
    .m_addr_i (m_addr_i),
    .m_data_i (m_data_i),
    .m_sel_i  (m_sel_i),
    .m_data_o (m_data_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .m_rty_o  (m_rty_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_addr_o (s_addr_o),
    .s_data_o (s_data_o),
    .s_sel_o  (s_sel_o),
    .s_data_i (s_data_i),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .s_rty_i  (s_rty_i),
    .gnt_o    (gnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit bit_of(input logic [NUM_M-1:0] v, input int k);
    logic [NUM_M-1:0] t;
    t = v >> k;
    return t[0];
  endfunction

  function automatic logic [NUM_M-1:0] onehot(input int k);
    return NUM_M'(1) << k;
  endfunction

  function automatic bit mdl_stalled();
    if (mdl_owner < 0) return 1'b0;
    return bit_of(m_cyc_i, mdl_owner) && bit_of(m_stb_i, mdl_owner) &&
           !(s_ack_i || s_err_i || s_rty_i);
  endfunction

  function automatic bit mdl_timeout();
    return TO_EN && mdl_stalled() && (mdl_stall + 1 == TO_CYC);
  endfunction

  // Advance the model across one rising edge using the inputs held during that cycle.
  function automatic void mdl_update();
    if (rst_i) begin
      mdl_owner = -1;
      mdl_ptr   = 0;
      mdl_stall = 0;
    end else if (mdl_owner < 0) begin
      for (int j = 0; j < NUM_M; j++) begin
        int k;
        k = (mdl_ptr + j) % NUM_M;
        if (mdl_owner < 0 && bit_of(m_cyc_i, k)) mdl_owner = k;
      end
      mdl_stall = 0;
    end else if (!bit_of(m_cyc_i, mdl_owner)) begin
      mdl_ptr   = (mdl_owner + 1) % NUM_M;
      mdl_owner = -1;
      mdl_stall = 0;
    end else begin
      mdl_stall = (mdl_stalled() && !mdl_timeout()) ? mdl_stall + 1 : 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [NUM_M-1:0]    e_gnt, e_ack, e_err, e_rty;
    logic                e_cyc, e_stb, e_we, to;
    logic [AW-1:0]       e_addr;
    logic [DW-1:0]       e_data;
    logic [SW-1:0]       e_sel;
    logic [NUM_M*AW-1:0] a_t;
    logic [NUM_M*DW-1:0] d_t;
    logic [NUM_M*SW-1:0] s_t;
    e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_addr = '0; e_data = '0; e_sel = '0;
    if (mdl_owner >= 0) begin
      to     = mdl_timeout();
      e_gnt  = onehot(mdl_owner);
      e_cyc  = bit_of(m_cyc_i, mdl_owner);
      e_stb  = e_cyc && bit_of(m_stb_i, mdl_owner) && !to;
      e_we   = bit_of(m_we_i, mdl_owner);
      a_t    = m_addr_i >> (mdl_owner * AW);
      d_t    = m_data_i >> (mdl_owner * DW);
      s_t    = m_sel_i >> (mdl_owner * SW);
      e_addr = a_t[AW-1:0];
      e_data = d_t[DW-1:0];
      e_sel  = s_t[SW-1:0];
      e_ack  = s_ack_i ? onehot(mdl_owner) : '0;
      e_err  = (s_err_i || to) ? onehot(mdl_owner) : '0;
      e_rty  = s_rty_i ? onehot(mdl_owner) : '0;
    end
    chk("gnt_o",    32'(gnt_o),    32'(e_gnt));
    chk("s_cyc_o",  32'(s_cyc_o),  32'(e_cyc));
    chk("s_stb_o",  32'(s_stb_o),  32'(e_stb));
    chk("s_we_o",   32'(s_we_o),   32'(e_we));
    chk("s_addr_o", 32'(s_addr_o), 32'(e_addr));
    chk("s_data_o", 32'(s_data_o), 32'(e_data));
    chk("s_sel_o",  32'(s_sel_o),  32'(e_sel));
    chk("m_ack_o",  32'(m_ack_o),  32'(e_ack));
    chk("m_err_o",  32'(m_err_o),  32'(e_err));
    chk("m_rty_o",  32'(m_rty_o),  32'(e_rty));
    chk("m_data_o", 32'(m_data_o), 32'(s_data_i));
  endtask

  task automatic applyStimulus(input logic [NUM_M-1:0] cyc, input logic [NUM_M-1:0] stb,
                               input logic ack, input logic err, input logic rty);
    m_cyc_i  = cyc;
    m_stb_i  = stb;
    m_we_i   = NUM_M'($urandom);
    m_addr_i = {$urandom, $urandom, $urandom, $urandom};
    m_data_i = {$urandom, $urandom, $urandom, $urandom};
    m_sel_i  = (NUM_M*SW)'($urandom);
    s_ack_i  = ack;
    s_err_i  = err;
    s_rty_i  = rty;
    s_data_i = $urandom;
  endtask

  // Check outputs mid-cycle, then step the model across the rising edge.
  task automatic tick();
    @(negedge clk_i);
    checkOutput();
    @(posedge clk_i);
    mdl_update();
    #1;
  endtask

  initial begin
    int order [6] = '{0, 1, 3, 0, 1, 3};
    int first_err;
    int err_cnt;

    rst_i = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;

    // 1) reset and quiet bus
    tick();
    chk("reset_gnt", 32'(gnt_o), 32'h0);
    chk("reset_scyc", 32'(s_cyc_o), 32'h0);
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
      tick();
    end

    // 2) master 2 single read, ACK on its 2nd owned cycle
    applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
    m_we_i[2] = 1'b0;
    m_addr_i[95:64] = 32'h1000_0004;
    tick();
    chk("m2_gnt", 32'(gnt_o), 32'h4);
    chk("m2_addr", 32'(s_addr_o), 32'h1000_0004);
    tick();
    s_ack_i  = 1'b1;
    s_data_i = 32'hCAFE_F00D;
    #1;
    chk("m2_ack", 32'(m_ack_o), 32'h4);
    chk("m2_rdata", 32'(m_data_o), 32'hCAFE_F00D);
    tick();
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("m2_ack_gone", 32'(m_ack_o), 32'h0);
    tick();
    chk("m2_released", 32'(gnt_o), 32'h0);

    // 3) masters 0,1,3 contend from a fresh pointer
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int t = 0; t < 6; t++) begin
      applyStimulus(4'b1011, 4'b1011, 1'b0, 1'b0, 1'b0);
      tick();
      chk("rr_grant", 32'(gnt_o), 32'(onehot(order[t])));
      s_ack_i = 1'b1;
      tick();
      applyStimulus(4'b1011 & ~onehot(order[t]), 4'b1011 & ~onehot(order[t]), 1'b0, 1'b0, 1'b0);
      tick();
      chk("rr_idle_gap", 32'(gnt_o), 32'h0);
    end
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
    tick();

    // 4) master 1 bursts 4 beats while master 0 waits
    applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0);
    tick();
    chk("burst_gnt", 32'(gnt_o), 32'h2);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(4'b0011, 4'b0011, 1'b1, 1'b0, 1'b0);
      #1;
      chk("burst_ack", 32'(m_ack_o), 32'h2);
      tick();
    end
    applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick();
    chk("burst_idle", 32'(gnt_o), 32'h0);
    tick();
    chk("burst_next", 32'(gnt_o), 32'h1);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // 5) hung slave: master 0 strobes with no response
    applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick();
    first_err = 0;
    err_cnt   = 0;
    for (int i = 1; i <= STALL_LEN; i++) begin
      #1;
      if (m_err_o[0]) begin
        err_cnt++;
        if (first_err == 0) first_err = i;
      end
      tick();
    end
    if (TO_EN) begin
      chk("timeout_first", 32'(first_err), 32'(TO_CYC));
      chk("timeout_count", 32'(err_cnt), 32'(STALL_LEN / TO_CYC));
    end else begin
      chk("no_timeout", 32'(err_cnt), 32'h0);
    end

    // 6) reset in the middle of a tenure
    m_cyc_i = 4'b1011;
    m_stb_i = 4'b1011;
    rst_i   = 1'b1;
    tick();
    chk("rst_mid_gnt", 32'(gnt_o), 32'h0);
    chk("rst_mid_scyc", 32'(s_cyc_o), 32'h0);
    rst_i = 1'b0;
    applyStimulus(4'b1010, 4'b1010, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_first_gnt", 32'(gnt_o), 32'h2);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // 7) random traffic; each CYC bit toggles occasionally so tenures span several cycles
    for (int i = 0; i < 600; i++) begin
      logic [NUM_M-1:0] flip;
      flip = NUM_M'($urandom) & NUM_M'($urandom);
      applyStimulus(m_cyc_i ^ flip, NUM_M'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 15) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
